id_ex_latch: RTL and testbench
==============================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameter len, default 32, data path width.
REQ-002 Parameter nb_reg, default 5, register address width.
REQ-003 Parameter nb_ctrl, default 9, width of packed EX/MEM/WB control word.
REQ-004 i_clk  input  1  single clock, all state on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_enable  input  1  pipeline advance enable from debug unit; 0 holds all state.
REQ-007 i_flush  input  1  branch/jump taken; squash instruction entering EX.
REQ-008 i_add_pc  input  len  PC+4 from decode.
REQ-009 i_dato1 / i_dato2  input  len  rs/rt register file read data.
REQ-010 i_extend_sign  input  len  sign-extended immediate.
REQ-011 i_rs / i_rt / i_rd  input  nb_reg  register addresses.
REQ-012 i_ctrl  input  nb_ctrl  control word; bit 0 = mem_read, bit 1 = reg_write.
REQ-013 o_add_pc, o_dato1, o_dato2, o_extend_sign  output  len  registered copies for execute.
REQ-014 o_rs, o_rt, o_rd  output  nb_reg  registered addresses.
REQ-015 o_ctrl  output  nb_ctrl  registered control word.
REQ-016 o_stall  output  1  combinational load-use stall to PC and IF/ID.
REQ-017 o_valid  output  1  registered; 1 when EX holds a real instruction.

Function
REQ-018 Hazard: o_stall = o_valid & o_ctrl[0] & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)), else 0.
REQ-019 Latency one cycle: when i_enable=1, i_flush=0, o_stall=0, every output register loads its input on the edge.
REQ-020 Bubble: when i_enable=1 and (o_stall=1 or i_flush=1), o_ctrl loads 0 and o_valid loads 0; data/address registers load inputs (don't-care).
REQ-021 Simultaneous i_flush and o_stall: treated as bubble, one cycle only.
REQ-022 Stall lasts exactly one cycle per load-use pair: after the bubble, o_valid=0 forces o_stall=0.
REQ-023 i_enable=0: all registers hold, including o_valid; o_stall still evaluated combinationally.
REQ-024 Register address 0 never produces a stall.
REQ-025 No arithmetic; all widths passed through unchanged.

Reset
REQ-026 On i_rst_n=0, immediately: all len/nb_reg/nb_ctrl outputs 0, o_valid 0, hence o_stall 0.
REQ-027 Reset mid-stall discards the pending instruction; first edge after release with i_enable=1 loads inputs normally.

Configuration
REQ-028 Macro ID_EX_STALL_COUNT_EN defined: 32-bit output o_stall_count increments on each edge with i_enable=1 and o_stall=1, saturates at all-ones, cleared by reset.
REQ-029 Macro undefined: o_stall_count port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package holds control-word bit-position constants (mem_read, reg_write, mem_write, alu_src, alu_op field, reg_dst) and nb_ctrl.
REQ-031 One sub-module, hazard_detect, containing REQ-018 logic only; remainder in id_ex_latch.

Verification
REQ-032 Reset: assert i_rst_n=0 with all inputs 0xFFFFFFFF -> all outputs 0, o_stall 0.
REQ-033 Pass-through: i_add_pc=0x104, i_dato1=0x11, i_ctrl=0x002 -> next edge o_add_pc=0x104, o_dato1=0x11, o_ctrl=0x002, o_valid=1.
REQ-034 Load-use: EX holds lw o_rt=8, o_ctrl[0]=1; ID presents i_rs=8 -> o_stall=1; next edge o_ctrl=0, o_valid=0, o_stall=0.
REQ-035 Zero register: EX lw o_rt=0, i_rs=0 -> o_stall=0, instruction advances.
REQ-036 Flush and hold: i_flush=1 -> next o_valid=0; then i_enable=0 for 3 cycles with changing inputs -> outputs unchanged.
REQ-037 With ID_EX_STALL_COUNT_EN: three load-use pairs -> o_stall_count=3; reset -> 0.

Source files
------------

// File: rtl/id_ex_latch_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_latch_pkg
// Shared definitions for the ID/EX pipeline latch.
// Holds the default control word width and the bit position of each field
// inside the packed EX/MEM/WB control word carried from decode to execute.
// Control word layout (LSB first):
//   [0]   mem_read   - instruction is a load
//   [1]   reg_write  - instruction writes the register file
//   [2]   mem_write  - instruction is a store
//   [3]   alu_src    - ALU B operand comes from the immediate
//   [7:4] alu_op     - ALU operation selector
//   [8]   reg_dst    - destination is rd (1) or rt (0)
// ---------------------------------------------------------------------------
package id_ex_latch_pkg;

  localparam int NB_CTRL        = 9;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_REG_WRITE = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_ALU_OP_LSB = 4;
  localparam int CTRL_ALU_OP_W  = 4;
  localparam int CTRL_REG_DST   = 8;

endpackage

// File: rtl/id_ex_latch_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. A load sitting in EX whose target
// register is read by the instruction in ID forces a one-cycle stall.
// Register 0 is hard-wired to zero, so it never creates a dependency.
// Ports:
//   ex_valid     in   EX stage holds a real instruction
//   ex_mem_read  in   EX instruction is a load
//   ex_rt        in   load destination register in EX
//   id_rs/id_rt  in   source registers of the instruction in ID
//   stall        out  load-use stall request
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int nb_reg = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [nb_reg-1:0] ex_rt,
  input  logic [nb_reg-1:0] id_rs,
  input  logic [nb_reg-1:0] id_rt,
  output logic              stall
);

  assign stall = ex_valid & ex_mem_read & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// On an enabled edge the decode outputs are captured for execute; when a
// load-use stall or a taken branch/jump flush is present, the control word and
// valid bit are cleared instead so EX receives a bubble. i_enable=0 freezes
// everything (debug single-step).
// Optional feature: define ID_EX_STALL_COUNT_EN to add a saturating 32-bit
// stall counter on port o_stall_count.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_enable, i_flush               advance enable, squash request
//   i_add_pc, i_dato1, i_dato2,
//   i_extend_sign                   decode data (len bits)
//   i_rs, i_rt, i_rd                register addresses (nb_reg bits)
//   i_ctrl                          packed control word (nb_ctrl bits)
//   o_*                             registered copies for execute
//   o_stall                         combinational stall to PC and IF/ID
//   o_valid                         EX holds a real instruction
//   o_stall_count                   stall counter (only with the macro)
// ---------------------------------------------------------------------------
module id_ex_latch
  import id_ex_latch_pkg::*;
#(
  parameter int len     = 32,
  parameter int nb_reg  = 5,
  parameter int nb_ctrl = NB_CTRL
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic [len-1:0]     i_add_pc,
  input  logic [len-1:0]     i_dato1,
  input  logic [len-1:0]     i_dato2,
  input  logic [len-1:0]     i_extend_sign,
  input  logic [nb_reg-1:0]  i_rs,
  input  logic [nb_reg-1:0]  i_rt,
  input  logic [nb_reg-1:0]  i_rd,
  input  logic [nb_ctrl-1:0] i_ctrl,
  output logic [len-1:0]     o_add_pc,
  output logic [len-1:0]     o_dato1,
  output logic [len-1:0]     o_dato2,
  output logic [len-1:0]     o_extend_sign,
  output logic [nb_reg-1:0]  o_rs,
  output logic [nb_reg-1:0]  o_rt,
  output logic [nb_reg-1:0]  o_rd,
  output logic [nb_ctrl-1:0] o_ctrl,
  output logic               o_stall,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [31:0]        o_stall_count,
`endif
  output logic               o_valid
);

  logic bubble;

  hazard_detect #(.nb_reg(nb_reg)) u_hazard_detect (
    .ex_valid    (o_valid),
    .ex_mem_read (o_ctrl[CTRL_MEM_READ]),
    .ex_rt       (o_rt),
    .id_rs       (i_rs),
    .id_rt       (i_rt),
    .stall       (o_stall)
  );

  // A stall and a flush both resolve to the same single bubble; the bubble
  // clears o_valid, which in turn drops the stall on the following cycle.
  assign bubble = o_stall | i_flush;

  // Data and addresses always follow the inputs when enabled; in a bubble
  // they are meaningless because the control word and valid are zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_add_pc      <= '0;
      o_dato1       <= '0;
      o_dato2       <= '0;
      o_extend_sign <= '0;
      o_rs          <= '0;
      o_rt          <= '0;
      o_rd          <= '0;
      o_ctrl        <= '0;
      o_valid       <= 1'b0;
    end else if (i_enable) begin
      o_add_pc      <= i_add_pc;
      o_dato1       <= i_dato1;
      o_dato2       <= i_dato2;
      o_extend_sign <= i_extend_sign;
      o_rs          <= i_rs;
      o_rt          <= i_rt;
      o_rd          <= i_rd;
      o_ctrl        <= bubble ? '0 : i_ctrl;
      o_valid       <= ~bubble;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  // Counts stall bubbles actually inserted; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_count <= '0;
    end else if (i_enable && o_stall && (o_stall_count != '1)) begin
      o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_latch
// Self-checking bench for id_ex_latch. A reference model of the latch state
// is advanced for every driven cycle, its expected outputs are queued, and
// the queue is popped and compared once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_id_ex_latch;
  import id_ex_latch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_add_pc = '0, i_dato1 = '0, i_dato2 = '0, i_extend_sign = '0;
  logic [4:0]  i_rs = '0, i_rt = '0, i_rd = '0;
  logic [8:0]  i_ctrl = '0;
  logic [31:0] o_add_pc, o_dato1, o_dato2, o_extend_sign;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [8:0]  o_ctrl;
  logic        o_stall, o_valid;
`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] o_stall_count;
`endif

  id_ex_latch #(.len(32), .nb_reg(5), .nb_ctrl(9)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_flush       (i_flush),
    .i_add_pc      (i_add_pc),
    .i_dato1       (i_dato1),
    .i_dato2       (i_dato2),
    .i_extend_sign (i_extend_sign),
    .i_rs          (i_rs),
    .i_rt          (i_rt),
    .i_rd          (i_rd),
    .i_ctrl        (i_ctrl),
    .o_add_pc      (o_add_pc),
    .o_dato1       (o_dato1),
    .o_dato2       (o_dato2),
    .o_extend_sign (o_extend_sign),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_ctrl        (o_ctrl),
    .o_stall       (o_stall),
`ifdef ID_EX_STALL_COUNT_EN
    .o_stall_count (o_stall_count),
`endif
    .o_valid       (o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] add_pc, d1, d2, ext;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
    logic        valid;
    logic        data_known;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   n_compared = 0;
  int   n_mismatched = 0;

  localparam logic [8:0] C_LW  = 9'h003;
  localparam logic [8:0] C_ALU = 9'h002;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic model_stall(input logic [4:0] rs, input logic [4:0] rt);
    return m.valid & m.ctrl[CTRL_MEM_READ] & (m.rt != 5'd0) & ((m.rt == rs) | (m.rt == rt));
  endfunction

  task automatic compare_registered(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'(e.valid));
    checkOutput({tag, "_ctrl"}, 32'(o_ctrl), 32'(e.ctrl));
    if (e.data_known) begin
      checkOutput({tag, "_add_pc"}, o_add_pc, e.add_pc);
      checkOutput({tag, "_dato1"}, o_dato1, e.d1);
      checkOutput({tag, "_dato2"}, o_dato2, e.d2);
      checkOutput({tag, "_ext"}, o_extend_sign, e.ext);
      checkOutput({tag, "_rs"}, 32'(o_rs), 32'(e.rs));
      checkOutput({tag, "_rt"}, 32'(o_rt), 32'(e.rt));
      checkOutput({tag, "_rd"}, 32'(o_rd), 32'(e.rd));
    end
`ifdef ID_EX_STALL_COUNT_EN
    checkOutput({tag, "_stall_count"}, o_stall_count, e.cnt);
`endif
  endtask

  // Drive one cycle of decode outputs, check the combinational stall before
  // the edge, then check the registered result after it.
  task automatic applyStimulus(input string tag, input logic en, input logic fl,
                               input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] ext,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [8:0] ctrl);
    logic st;
    @(negedge i_clk);
    i_enable = en; i_flush = fl; i_add_pc = pc; i_dato1 = a; i_dato2 = b;
    i_extend_sign = ext; i_rs = rs; i_rt = rt; i_rd = rd; i_ctrl = ctrl;
    #1;
    st = model_stall(rs, rt);
    checkOutput({tag, "_stall"}, 32'(o_stall), 32'(st));
    if (en) begin
      if (st && m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 32'd1;
      m.add_pc = pc; m.d1 = a; m.d2 = b; m.ext = ext;
      m.rs = rs; m.rt = rt; m.rd = rd;
      m.valid = !(st || fl);
      m.ctrl = (st || fl) ? 9'd0 : ctrl;
      m.data_known = !(st || fl);
    end
    exp_q.push_back(m);
    @(posedge i_clk);
    #1;
    compare_registered(tag);
  endtask

  // Asynchronous reset with every input at all-ones; outputs must clear
  // without waiting for a clock edge.
  task automatic do_reset();
    i_enable = 1'b1; i_flush = 1'b1; i_add_pc = '1; i_dato1 = '1; i_dato2 = '1;
    i_extend_sign = '1; i_rs = '1; i_rt = '1; i_rd = '1; i_ctrl = '1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_add_pc", o_add_pc, 32'd0);
    checkOutput("rst_dato1", o_dato1, 32'd0);
    checkOutput("rst_dato2", o_dato2, 32'd0);
    checkOutput("rst_ext", o_extend_sign, 32'd0);
    checkOutput("rst_rs", 32'(o_rs), 32'd0);
    checkOutput("rst_rt", 32'(o_rt), 32'd0);
    checkOutput("rst_rd", 32'(o_rd), 32'd0);
    checkOutput("rst_ctrl", 32'(o_ctrl), 32'd0);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
`ifdef ID_EX_STALL_COUNT_EN
    checkOutput("rst_stall_count", o_stall_count, 32'd0);
`endif
    m = '{add_pc: '0, d1: '0, d2: '0, ext: '0, rs: '0, rt: '0, rd: '0,
          ctrl: '0, valid: 1'b0, data_known: 1'b1, cnt: '0};
    @(negedge i_clk);
    i_enable = 1'b0; i_flush = 1'b0; i_add_pc = '0; i_dato1 = '0; i_dato2 = '0;
    i_extend_sign = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_ctrl = '0;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #3;
    $display("[TB] reset with all inputs high");
    do_reset();

    $display("[TB] pass-through");
    applyStimulus("pass", 1, 0, 32'h104, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, C_ALU);

    $display("[TB] load-use pairs");
    applyStimulus("lw1", 1, 0, 32'h108, 32'h1, 32'h2, 32'h4, 5'd4, 5'd8, 5'd0, C_LW);
    applyStimulus("use1", 1, 0, 32'h10C, 32'h5, 32'h6, 32'h7, 5'd8, 5'd9, 5'd10, C_ALU);
    applyStimulus("use1_retry", 1, 0, 32'h10C, 32'h5, 32'h6, 32'h7, 5'd8, 5'd9, 5'd10, C_ALU);
    applyStimulus("lw2", 1, 0, 32'h110, 32'h8, 32'h9, 32'hA, 5'd3, 5'd12, 5'd0, C_LW);
    applyStimulus("use2", 1, 0, 32'h114, 32'hB, 32'hC, 32'hD, 5'd1, 5'd12, 5'd2, C_ALU);
    applyStimulus("use2_retry", 1, 0, 32'h114, 32'hB, 32'hC, 32'hD, 5'd1, 5'd12, 5'd2, C_ALU);
    applyStimulus("lw3", 1, 0, 32'h118, 32'hE, 32'hF, 32'h10, 5'd2, 5'd31, 5'd0, C_LW);
    applyStimulus("use3", 1, 0, 32'h11C, 32'h12, 32'h13, 32'h14, 5'd31, 5'd31, 5'd4, C_ALU);
    applyStimulus("use3_retry", 1, 0, 32'h11C, 32'h12, 32'h13, 32'h14, 5'd31, 5'd31, 5'd4, C_ALU);

    $display("[TB] zero register");
    applyStimulus("lw_r0", 1, 0, 32'h120, 32'h1, 32'h1, 32'h1, 5'd5, 5'd0, 5'd0, C_LW);
    applyStimulus("use_r0", 1, 0, 32'h124, 32'h2, 32'h3, 32'h4, 5'd0, 5'd0, 5'd6, C_ALU);

    $display("[TB] flush then hold");
    applyStimulus("flush", 1, 1, 32'h128, 32'h5, 32'h5, 32'h5, 5'd1, 5'd2, 5'd3, C_ALU);
    for (int k = 0; k < 3; k++)
      applyStimulus("hold_flush", 0, 0, 32'h200 + 32'(k), 32'hA0 + 32'(k), 32'hB0, 32'hC0,
                    5'(k + 1), 5'(k + 2), 5'(k + 3), 9'h1FF);

    $display("[TB] hold of a valid instruction");
    applyStimulus("load_valid", 1, 0, 32'h300, 32'hDEAD, 32'hBEEF, 32'hFFFF_FFF0, 5'd7, 5'd14, 5'd21, 9'h155);
    for (int k = 0; k < 3; k++)
      applyStimulus("hold_valid", 0, 1, 32'h400 + 32'(k), 32'h1, 32'h2, 32'h3,
                    5'd14, 5'd14, 5'd1, 9'h0AA);

    $display("[TB] flush coinciding with stall");
    applyStimulus("lw_fs", 1, 0, 32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd5, 5'd0, C_LW);
    applyStimulus("flush_stall", 1, 1, 32'h504, 32'h4, 32'h5, 32'h6, 5'd5, 5'd2, 5'd3, C_ALU);
    applyStimulus("after_fs", 1, 0, 32'h508, 32'h7, 32'h8, 32'h9, 5'd5, 5'd2, 5'd3, C_ALU);

    $display("[TB] stall while disabled");
    applyStimulus("lw_dis", 1, 0, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd7, 5'd0, C_LW);
    applyStimulus("stall_dis", 0, 0, 32'h604, 32'h4, 32'h5, 32'h6, 5'd7, 5'd2, 5'd3, C_ALU);
    applyStimulus("stall_en", 1, 0, 32'h604, 32'h4, 32'h5, 32'h6, 5'd7, 5'd2, 5'd3, C_ALU);
    applyStimulus("after_dis", 1, 0, 32'h604, 32'h4, 32'h5, 32'h6, 5'd7, 5'd2, 5'd3, C_ALU);

    $display("[TB] reset during a stall");
    applyStimulus("lw_rst", 1, 0, 32'h700, 32'h1, 32'h2, 32'h3, 5'd1, 5'd6, 5'd0, C_LW);
    @(negedge i_clk);
    i_enable = 1'b1; i_flush = 1'b0; i_rs = 5'd6; i_rt = 5'd0;
    #1;
    checkOutput("pre_rst_stall", 32'(o_stall), 32'd1);
    #1;
    do_reset();
    applyStimulus("post_rst", 1, 0, 32'h704, 32'h44, 32'h55, 32'h66, 5'd6, 5'd0, 5'd9, C_ALU);

    $display("[TB] random traffic");
    for (int k = 0; k < 60; k++) begin
      logic [8:0] c;
      c = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0) c[CTRL_MEM_READ] = 1'b1;
      applyStimulus("rand", ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0),
                    $urandom, $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 31)), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Backstop so the run always ends even if a task were to block.
  initial begin
    #200000;
    n_mismatched++;
    $display("[TB] FAIL timeout: got no completion, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
